// File: rtl/rns_fwd_conv.sv
`timescale 1ns/1ps
// Sequential binary-to-residue converter for moduli {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}.
// It consumes the operand MSB-first, one N-bit chunk per clock, and returns R1..R4 over valid/ready.
module rns_fwd_conv #(
    parameter int N      = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      r1,
    output logic [N-1:0]      r2,
    output logic [N:0]        r3,
    output logic [N:0]        r4,
    output logic              busy
);
    localparam int K     = DATA_W / N;
    localparam int CNT_W = $clog2(K + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);
    localparam logic [N:0]       M1   = {1'b0, {N{1'b1}}};
    localparam logic [N:0]       M3   = {1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic [N+1:0]     M4   = {1'b0, {(N+1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] sreg_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [N-1:0]      a1_reg;
    logic [N:0]        a3_reg;
    logic [N:0]        a4_reg;

    logic [N-1:0]      b;
    logic [N:0]        s1;
    logic [N:0]        rot4;
    logic [N+1:0]      s4;
    logic [N-1:0]      a1_next;
    logic [N-1:0]      a2_next;
    logic [N:0]        a3_next;
    logic [N:0]        a4_next;

    // Horner step a <- a*2^N + b in each modulus; every sum is one bit wider and
    // a single conditional subtraction keeps the residue canonical.
    always_comb begin
        b       = sreg_reg[DATA_W-1 -: N];
        s1      = {1'b0, a1_reg} + {1'b0, b};
        a1_next = (s1 >= M1) ? (s1[N-1:0] - M1[N-1:0]) : s1[N-1:0];
        a2_next = b;
        // 2^N = -1 mod 2^N+1, so the step becomes b - a3
        a3_next = ({1'b0, b} >= a3_reg) ? ({1'b0, b} - a3_reg)
                                        : ({1'b0, b} + M3 - a3_reg);
        // 2^N * a4 mod 2^(N+1)-1 is a right rotation by one over N+1 bits
        rot4    = {a4_reg[0], a4_reg[N:1]};
        s4      = {1'b0, rot4} + {2'b00, b};
        a4_next = (s4 >= M4) ? (s4[N:0] - M4[N:0]) : s4[N:0];
    end

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            a1_reg    <= '0;
            a3_reg    <= '0;
            a4_reg    <= '0;
            out_valid <= 1'b0;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            r4        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sreg_reg  <= x;
                        cnt_reg   <= '0;
                        a1_reg    <= '0;
                        a3_reg    <= '0;
                        a4_reg    <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sreg_reg <= sreg_reg << N;
                    cnt_reg  <= cnt_reg + 1'b1;
                    a1_reg   <= a1_next;
                    a3_reg   <= a3_next;
                    a4_reg   <= a4_next;
                    if (cnt_reg == LAST) begin
                        r1        <= a1_next;
                        r2        <= a2_next;
                        r3        <= a3_next;
                        r4        <= a4_next;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rns_fwd_conv.md
# rns_fwd_conv

Sequential binary-to-residue forward converter for the moduli set {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}. It accepts a DATA_W-bit binary operand and computes the four canonical residues MSB-first, one N-bit chunk per clock. It sits directly upstream of the RNS reverse-conversion stage (S1–S4 / p1–p3 datapath) and feeds it R1..R4 through a valid/ready handshake.

## Interface
- N, 8, chunk width and modulus exponent; N ≥ 2
- DATA_W, 64, operand width; must be a multiple of N; K = DATA_W/N chunks
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand x is valid
- in_ready  out  1  converter can accept an operand
- x  in  DATA_W  binary operand, unsigned
- out_valid  out  1  residues valid
- out_ready  in  1  downstream consumes residues
- r1  out  N  x mod (2^N-1), range 0..2^N-2
- r2  out  N  x mod 2^N
- r3  out  N+1  x mod (2^N+1), range 0..2^N
- r4  out  N+1  x mod (2^(N+1)-1), range 0..2^(N+1)-2
- busy  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: latch x into a shift register, clear accumulators a1..a4 and chunk counter; go to RUN.
- RUN: each cycle take chunk b = top N bits of the shift register (MSB chunk first), shift left by N, increment counter. Updates (all modular, one correction step each):
  - a1 ← a1 + b; subtract 2^N-1 if ≥ 2^N-1 (a1 never holds 2^N-1).
  - a2 ← b.
  - a3 ← b − a3 if b ≥ a3, else b − a3 + 2^N+1 (2^N ≡ −1).
  - a4 ← rotr1(a4, N+1 bits) + b; subtract 2^(N+1)-1 if ≥ 2^(N+1)-1 (2^N·a4 ≡ rotate-right-by-1).
- After the K-th chunk: go to DONE, out_valid=1, r1..r4 = a1..a4.
- DONE: r1..r4 and out_valid held stable until out_valid & out_ready; then go to IDLE, out_valid=0.
- in_ready=0 in RUN and DONE; in_valid there is ignored, x not sampled.
- Internal sums one bit wider than the operands; no overflow is permitted to escape the correction step.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, r1..r4=0, accumulators and counter 0.
- Reset has priority over every other event; asserted mid-RUN or in DONE it aborts the conversion, drops out_valid on the next edge, and the pending result is lost.
- Latency: out_valid rises exactly K clocks after the accept edge (K=8 for defaults).
- Outputs are registered; no combinational path from in_valid/out_ready to out_valid/r*.
- in_ready is combinational from state only.
- Throughput with out_ready held high: one operand per K+2 cycles (accept, K RUN, DONE handshake, back in IDLE).
- out_ready low in DONE: stall indefinitely, outputs unchanged.
- out_ready high before DONE has no effect.

## Test plan
- Reset, then x=0, out_ready=1 → after 8 cycles out_valid=1, r1=0, r2=0, r3=0, r4=0; in_ready returns to 1 the cycle after the handshake.
- x=1000 → r1=235, r2=232, r3=229, r4=489.
- x=511 → r1=1, r2=255, r3=254, r4=0 (canonical, never 511); x=2^64−1 → r1=0, r2=255, r3=0, r4=1.
- Backpressure: x=1000, out_ready=0 for 20 cycles in DONE → r1..r4 stable at 235/232/229/489, in_ready=0, in_valid pulses with other x ignored; raise out_ready → single handshake, out_valid drops next edge.
- Reset asserted on 4th RUN cycle of x=1000 → next edge out_valid=0, r*=0, in_ready=1; following x=0x1FF converts correctly (1/255/254/0).
- Random sweep: 10^4 random 64-bit x, back-to-back with random out_ready → every r* matches x mod {255,256,257,511} against a golden model, no dropped or duplicated results.
